// File: rtl/mem_to_axilite_bridge.sv
`timescale 1ns/1ps
// Bridges one PicoRV32-style MEM request port onto an AXI4-Lite master port.
// A single transaction is in flight at a time; payload is captured at grant.
module mem_to_axilite_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [2:0]  AXI_PROT   = 3'b000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      mem_req_i,
    output logic                      mem_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
    input  logic                      mem_we_i,
    input  logic [DATA_WIDTH/8-1:0]   mem_be_i,
    input  logic [DATA_WIDTH-1:0]     mem_wdata_i,
    output logic                      mem_valid_o,
    output logic [DATA_WIDTH-1:0]     mem_rdata_o,
    output logic                      mem_error_o,

    output logic                      awvalid_o,
    input  logic                      awready_i,
    output logic [ADDR_WIDTH-1:0]     awaddr_o,
    output logic [2:0]                awprot_o,

    output logic                      wvalid_o,
    input  logic                      wready_i,
    output logic [DATA_WIDTH-1:0]     wdata_o,
    output logic [DATA_WIDTH/8-1:0]   wstrb_o,

    input  logic                      bvalid_i,
    output logic                      bready_o,
    input  logic [1:0]                bresp_i,

    output logic                      arvalid_o,
    input  logic                      arready_i,
    output logic [ADDR_WIDTH-1:0]     araddr_o,
    output logic [2:0]                arprot_o,

    input  logic                      rvalid_i,
    output logic                      rready_o,
    input  logic [DATA_WIDTH-1:0]     rdata_i,
    input  logic [1:0]                rresp_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RRESP,
        RESP
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
    logic [STRB_WIDTH-1:0]  be_reg, be_next;
    logic [DATA_WIDTH-1:0]  wdata_reg, wdata_next;
    logic                   aw_done_reg, aw_done_next;
    logic                   w_done_reg, w_done_next;
    logic [DATA_WIDTH-1:0]  rdata_reg, rdata_next;
    logic                   error_reg, error_next;
    logic                   grant;

    // Only bit 1 of an AXI response distinguishes OKAY/EXOKAY from an error.
    logic unused_resp_lsb;
    assign unused_resp_lsb = bresp_i[0] ^ rresp_i[0];

    // Byte lanes load together on grant and then hold for the whole transaction.
    generate
        for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
            assign be_next[gi]           = grant ? mem_be_i[gi] : be_reg[gi];
            assign wdata_next[8*gi +: 8] = grant ? mem_wdata_i[8*gi +: 8] : wdata_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            be_reg      <= '0;
            wdata_reg   <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            rdata_reg   <= '0;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            be_reg      <= be_next;
            wdata_reg   <= wdata_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            rdata_reg   <= rdata_next;
            error_reg   <= error_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        rdata_next   = rdata_reg;
        error_next   = error_reg;
        grant        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (mem_req_i) begin
                    grant        = 1'b1;
                    addr_next    = mem_addr_i;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = mem_we_i ? WRITE : READ;
                end
            end
            WRITE: begin
                // AW and W complete independently, possibly in the same cycle.
                aw_done_next = aw_done_reg | (awvalid_o & awready_i);
                w_done_next  = w_done_reg | (wvalid_o & wready_i);
                if (aw_done_next && w_done_next) begin
                    state_next = WRESP;
                end
            end
            WRESP: begin
                if (bvalid_i) begin
                    rdata_next = '0;
                    error_next = bresp_i[1];
                    state_next = RESP;
                end
            end
            READ: begin
                if (arready_i) begin
                    state_next = RRESP;
                end
            end
            RRESP: begin
                if (rvalid_i) begin
                    rdata_next = rdata_i;
                    error_next = rresp_i[1];
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_gnt_o   = grant;
    assign mem_valid_o = (state_reg == RESP);
    assign mem_rdata_o = rdata_reg;
    assign mem_error_o = error_reg;

    assign awvalid_o   = (state_reg == WRITE) && !aw_done_reg;
    assign awaddr_o    = addr_reg;
    assign awprot_o    = AXI_PROT;

    assign wvalid_o    = (state_reg == WRITE) && !w_done_reg;
    assign wdata_o     = wdata_reg;
    assign wstrb_o     = be_reg;

    assign bready_o    = (state_reg == WRESP);

    assign arvalid_o   = (state_reg == READ);
    assign araddr_o    = addr_reg;
    assign arprot_o    = AXI_PROT;

    assign rready_o    = (state_reg == RRESP);

endmodule

// File: doc/mem_to_axilite_bridge.md
Name: mem_to_axilite_bridge

Overview:
- Converts one MEM-protocol master port (PicoRV32 core wrapper, instr or data side) into an AXI4-Lite master port on the SoC crossbar.
- Sits directly downstream of the core wrapper; one instance per MEM port.
- Allows a single outstanding transaction; registers address, data and strobes at grant and returns one registered response.

Parameters:
- ADDR_WIDTH, 32, MEM and AXI address width.
- DATA_WIDTH, 32, data width; must be 32. Strobe width is DATA_WIDTH/8.
- AXI_PROT, 3'b000, constant driven on awprot_o/arprot_o.

Ports:
- clk_i in 1: clock.
- rst_ni in 1: reset, asynchronous, active-low.
- mem_req_i in 1: MEM request.
- mem_gnt_o out 1: request accepted.
- mem_addr_i in ADDR_WIDTH: address.
- mem_we_i in 1: 1 = write.
- mem_be_i in DATA_WIDTH/8: byte enables.
- mem_wdata_i in DATA_WIDTH: write data.
- mem_valid_o out 1: response valid, one-cycle pulse.
- mem_rdata_o out DATA_WIDTH: read data.
- mem_error_o out 1: response error.
- AXI write address: awvalid_o out 1; awready_i in 1; awaddr_o out ADDR_WIDTH; awprot_o out 3.
- AXI write data: wvalid_o out 1; wready_i in 1; wdata_o out DATA_WIDTH; wstrb_o out DATA_WIDTH/8.
- AXI write response: bvalid_i in 1; bready_o out 1; bresp_i in 2.
- AXI read address: arvalid_o out 1; arready_i in 1; araddr_o out ADDR_WIDTH; arprot_o out 3.
- AXI read data: rvalid_i in 1; rready_o out 1; rdata_i in DATA_WIDTH; rresp_i in 2.

Behaviour:
- Reset (rst_ni low, asynchronous): state = IDLE. All valid/ready/gnt outputs = 0. mem_rdata_o = 0, mem_error_o = 0. Address, data and strobe registers = 0.
- Reset asserted mid-transaction drops the transaction; no response is issued afterwards.
- States: IDLE, WRITE, WRESP, READ, RRESP, RESP.
- IDLE:
  - mem_gnt_o = mem_req_i (combinational, IDLE only).
  - On req: latch addr, be, wdata and we.
  - we=1 -> WRITE with awvalid_o=wvalid_o=1 next cycle.
  - we=0 -> READ with arvalid_o=1 next cycle.
- mem_gnt_o is 0 in every other state. Requests are held off until the bridge returns to IDLE.
- WRITE:
  - AW and W channels are independent.
  - Each valid drops the cycle after its own handshake (valid & ready).
  - Internal aw_done/w_done flags record completion; both handshakes may occur in the same cycle.
  - When both are done -> WRESP.
- WRESP:
  - bready_o = 1.
  - On bvalid_i: mem_error_o <= bresp_i[1], mem_rdata_o <= 0, go to RESP.
- READ: arvalid_o held until arready_i, then -> RRESP.
- RRESP:
  - rready_o = 1.
  - On rvalid_i: mem_rdata_o <= rdata_i, mem_error_o <= rresp_i[1], go to RESP.
- RESP: mem_valid_o = 1 for exactly one cycle, then -> IDLE. A new grant is possible in the cycle after RESP.
- AXI rule: once a valid is raised, it and its payload stay stable until the handshake. Payload outputs are driven from the latched registers.
- mem_rdata_o and mem_error_o hold their last values outside RESP. Consumers may only sample them while mem_valid_o=1.
- Minimum latency with all AXI readies/valids immediate:
  - Read: gnt at cycle 0, AR handshake at cycle 1, R handshake at cycle 2, mem_valid_o at cycle 3.
  - Write: same cycle counts.
- awprot_o = arprot_o = AXI_PROT at all times.
- Unexpected bvalid_i/rvalid_i outside WRESP/RRESP is ignored; the corresponding ready is 0.

Test Plan:
- Read, immediate readies:
  - Stimulus: req addr=0x0000_0100, we=0; rdata_i=0xDEADBEEF, rresp=00.
  - Response: gnt same cycle; araddr_o=0x100; mem_valid_o 3 cycles after gnt with rdata=0xDEADBEEF, error=0.
- Write, AW ready 3 cycles before W ready:
  - Stimulus: addr=0x200, be=4'b0011, wdata=0x1234_5678.
  - Response: awvalid_o drops after AW handshake while wvalid_o stays high; wstrb_o=0011; one mem_valid_o pulse after B; no second AW is issued.
- Error response:
  - Stimulus: read with rresp=2'b10 (SLVERR), then a write with bresp=2'b11 (DECERR).
  - Response: mem_error_o=1 on both mem_valid_o pulses.
- Backpressure and hold-off:
  - Stimulus: arready_i held low 10 cycles; second req asserted during the wait.
  - Response: arvalid_o and araddr_o stable throughout; gnt=0 until IDLE; second request granted the cycle after RESP.
- Reset mid-transaction:
  - Stimulus: drop rst_ni while in RRESP, then release.
  - Response: all outputs 0 immediately; no mem_valid_o pulse; next read completes normally.
- Back-to-back:
  - Stimulus: 100 random reads/writes with random AXI ready/valid delays against a reference memory.
  - Response: all read data matches the reference; exactly one mem_valid_o per gnt.
